// File: rtl/sensor_event_counter.sv
// Counts objects seen by the debounced IR sensor as a two-digit BCD value for the LCD,
// with a re-trigger hold-off and a rate-limited LCD refresh strobe.
//
//   state      | meaning
//   -----------+-----------------------------------------------------------
//   ST_IDLE    | waiting for a rising sensor edge; a rise counts one object
//   ST_PRESENT | object in front of the sensor, waiting for it to leave
//   ST_HOLDOFF | object left; sensor must stay low HOLDOFF cycles before IDLE
module sensor_event_counter #(
    parameter int HOLDOFF  = 25_000_000,
    parameter bit SATURATE = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sensor_clean,
    input  logic       clear_i,
    output logic [3:0] digit_tens,
    output logic [3:0] digit_units,
    output logic       count_pulse,
    output logic       update_o,
    output logic       overflow_o,
    output logic [1:0] state_o
);

    localparam int TW = (HOLDOFF < 1) ? 1 : $clog2(HOLDOFF + 1);
    localparam logic [TW-1:0] LOAD = (HOLDOFF > 0) ? TW'(HOLDOFF - 1) : '0;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESENT = 2'd1,
        ST_HOLDOFF = 2'd2
    } state_t;

    state_t        state;
    logic [TW-1:0] timer;
    logic          prev;
    logic          clear_prev;
    logic          init_done;
    logic          upd_req;

    logic rise;
    logic count_ev;
    logic at_99;
    logic clr_first;
    logic upd_src;

    assign rise      = sensor_clean & ~prev;
    assign count_ev  = (state == ST_IDLE) & rise & ~clear_i;
    assign at_99     = (digit_tens == 4'd9) && (digit_units == 4'd9);
    assign clr_first = clear_i & ~clear_prev;
    // Any change of the displayed value, plus the first cycle out of reset so the LCD shows 00
    assign upd_src   = clr_first | ~init_done | (count_ev & ~(at_99 & SATURATE));
    assign state_o   = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            prev        <= 1'b1;
            clear_prev  <= 1'b0;
            init_done   <= 1'b0;
            upd_req     <= 1'b0;
            state       <= ST_IDLE;
            timer       <= '0;
            digit_tens  <= 4'd0;
            digit_units <= 4'd0;
            count_pulse <= 1'b0;
            update_o    <= 1'b0;
            overflow_o  <= 1'b0;
        end else begin
            prev        <= sensor_clean;
            clear_prev  <= clear_i;
            init_done   <= 1'b1;
            count_pulse <= count_ev;
            // A request arriving while the strobe is high waits one cycle instead of stacking
            update_o    <= upd_req & ~update_o;
            upd_req     <= upd_src | (upd_req & update_o);

            case (state)
                ST_IDLE: begin
                    if (rise) state <= ST_PRESENT;
                end
                ST_PRESENT: begin
                    if (!sensor_clean) begin
                        if (HOLDOFF == 0) begin
                            state <= ST_IDLE;
                        end else begin
                            state <= ST_HOLDOFF;
                            timer <= LOAD;
                        end
                    end
                end
                ST_HOLDOFF: begin
                    if (sensor_clean) begin
                        timer <= LOAD;
                    end else if (timer == '0) begin
                        state <= ST_IDLE;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase

            if (clear_i) begin
                digit_tens  <= 4'd0;
                digit_units <= 4'd0;
                overflow_o  <= 1'b0;
            end else if (count_ev) begin
                if (at_99) begin
                    overflow_o <= 1'b1;
                    if (!SATURATE) begin
                        digit_tens  <= 4'd0;
                        digit_units <= 4'd0;
                    end
                end else if (digit_units == 4'd9) begin
                    digit_units <= 4'd0;
                    digit_tens  <= digit_tens + 4'd1;
                end else begin
                    digit_units <= digit_units + 4'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_sensor_event_counter.sv
// Directed bench for sensor_event_counter: a saturating and a wrapping instance
// share the same stimulus, HOLDOFF shortened to 8 cycles.
module tb_sensor_event_counter;

    logic       clk = 1'b0;
    logic       reset;
    logic       sensor_clean;
    logic       clear_i;

    logic [3:0] ds_tens, ds_units, dw_tens, dw_units;
    logic       ds_cp, ds_upd, ds_ovf, dw_cp, dw_upd, dw_ovf;
    logic [1:0] ds_state, dw_state;

    int checks = 0;
    int errors = 0;

    sensor_event_counter #(.HOLDOFF(8), .SATURATE(1'b1)) dut_sat (
        .clk(clk), .reset(reset), .sensor_clean(sensor_clean), .clear_i(clear_i),
        .digit_tens(ds_tens), .digit_units(ds_units), .count_pulse(ds_cp),
        .update_o(ds_upd), .overflow_o(ds_ovf), .state_o(ds_state)
    );

    sensor_event_counter #(.HOLDOFF(8), .SATURATE(1'b0)) dut_wrap (
        .clk(clk), .reset(reset), .sensor_clean(sensor_clean), .clear_i(clear_i),
        .digit_tens(dw_tens), .digit_units(dw_units), .count_pulse(dw_cp),
        .update_o(dw_upd), .overflow_o(dw_ovf), .state_o(dw_state)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Checks the same expectation on both instances
    task automatic chk2(input string tag, input logic [7:0] obs_s, input logic [7:0] obs_w,
                        input logic [7:0] exp);
        chk({tag, "_sat"}, obs_s, exp);
        chk({tag, "_wrap"}, obs_w, exp);
    endtask

    task automatic do_reset(input logic sens);
        reset        = 1'b1;
        sensor_clean = sens;
        clear_i      = 1'b0;
        repeat (2) step();
        reset = 1'b0;
    endtask

    initial begin
        // Reset release with sensor low: LCD refresh two cycles later
        do_reset(1'b0);
        chk2("rst_tens", {4'd0, ds_tens}, {4'd0, dw_tens}, 8'd0);
        chk2("rst_units", {4'd0, ds_units}, {4'd0, dw_units}, 8'd0);
        chk2("rst_state", {6'd0, ds_state}, {6'd0, dw_state}, 8'd0);
        chk2("rst_ovf", {7'd0, ds_ovf}, {7'd0, dw_ovf}, 8'd0);
        chk2("rst_upd", {7'd0, ds_upd}, {7'd0, dw_upd}, 8'd0);
        step();
        chk2("rel1_upd", {7'd0, ds_upd}, {7'd0, dw_upd}, 8'd0);
        chk2("rel1_cp", {7'd0, ds_cp}, {7'd0, dw_cp}, 8'd0);
        step();
        chk2("rel2_upd", {7'd0, ds_upd}, {7'd0, dw_upd}, 8'd1);
        chk2("rel2_cp", {7'd0, ds_cp}, {7'd0, dw_cp}, 8'd0);
        step();
        chk2("rel3_upd", {7'd0, ds_upd}, {7'd0, dw_upd}, 8'd0);

        // Reset release with sensor already high: not counted
        do_reset(1'b1);
        repeat (4) step();
        chk2("hi_rel_units", {4'd0, ds_units}, {4'd0, dw_units}, 8'd0);
        chk2("hi_rel_state", {6'd0, ds_state}, {6'd0, dw_state}, 8'd0);
        sensor_clean = 1'b0;
        repeat (10) step();
        sensor_clean = 1'b1;
        step();
        chk2("first_units", {4'd0, ds_units}, {4'd0, dw_units}, 8'd1);
        chk2("first_cp", {7'd0, ds_cp}, {7'd0, dw_cp}, 8'd1);
        chk2("first_upd0", {7'd0, ds_upd}, {7'd0, dw_upd}, 8'd0);
        chk2("first_state", {6'd0, ds_state}, {6'd0, dw_state}, 8'd1);
        step();
        chk2("first_cp_off", {7'd0, ds_cp}, {7'd0, dw_cp}, 8'd0);
        chk2("first_upd1", {7'd0, ds_upd}, {7'd0, dw_upd}, 8'd1);

        // Re-trigger inside the hold-off window
        repeat (3) step();
        sensor_clean = 1'b0;
        step();
        chk2("leave_state", {6'd0, ds_state}, {6'd0, dw_state}, 8'd2);
        repeat (2) step();
        sensor_clean = 1'b1;
        step();
        chk2("retrig_units", {4'd0, ds_units}, {4'd0, dw_units}, 8'd1);
        chk2("retrig_cp", {7'd0, ds_cp}, {7'd0, dw_cp}, 8'd0);
        chk2("retrig_state", {6'd0, ds_state}, {6'd0, dw_state}, 8'd2);
        step();
        sensor_clean = 1'b0;
        repeat (7) step();
        chk2("hold7_state", {6'd0, ds_state}, {6'd0, dw_state}, 8'd2);
        step();
        chk2("hold8_state", {6'd0, ds_state}, {6'd0, dw_state}, 8'd0);
        sensor_clean = 1'b1;
        step();
        chk2("second_units", {4'd0, ds_units}, {4'd0, dw_units}, 8'd2);
        chk2("second_cp", {7'd0, ds_cp}, {7'd0, dw_cp}, 8'd1);
        step();
        sensor_clean = 1'b0;
        repeat (10) step();

        // Count from 00 up to 99 with clean objects
        do_reset(1'b0);
        repeat (3) step();
        for (int i = 1; i <= 99; i++) begin
            sensor_clean = 1'b1;
            step();
            chk2("cnt_tens", {4'd0, ds_tens}, {4'd0, dw_tens}, 8'(i / 10));
            chk2("cnt_units", {4'd0, ds_units}, {4'd0, dw_units}, 8'(i % 10));
            chk2("cnt_cp", {7'd0, ds_cp}, {7'd0, dw_cp}, 8'd1);
            step();
            chk2("cnt_upd", {7'd0, ds_upd}, {7'd0, dw_upd}, 8'd1);
            sensor_clean = 1'b0;
            repeat (10) step();
        end
        chk2("pre_ovf", {7'd0, ds_ovf}, {7'd0, dw_ovf}, 8'd0);

        // 100th object: saturate vs wrap
        sensor_clean = 1'b1;
        step();
        chk("sat_tens", {4'd0, ds_tens}, 8'd9);
        chk("sat_units", {4'd0, ds_units}, 8'd9);
        chk("wrap_tens", {4'd0, dw_tens}, 8'd0);
        chk("wrap_units", {4'd0, dw_units}, 8'd0);
        chk2("ovf_set", {7'd0, ds_ovf}, {7'd0, dw_ovf}, 8'd1);
        chk2("ovf_cp", {7'd0, ds_cp}, {7'd0, dw_cp}, 8'd1);
        step();
        chk("sat_upd", {7'd0, ds_upd}, 8'd0);
        chk("wrap_upd", {7'd0, dw_upd}, 8'd1);
        step();
        chk("sat_upd_late", {7'd0, ds_upd}, 8'd0);
        sensor_clean = 1'b0;
        repeat (10) step();

        // Clear in the same cycle as a rise: clear wins, FSM still tracks the object
        sensor_clean = 1'b1;
        clear_i      = 1'b1;
        step();
        chk2("clr_tens", {4'd0, ds_tens}, {4'd0, dw_tens}, 8'd0);
        chk2("clr_units", {4'd0, ds_units}, {4'd0, dw_units}, 8'd0);
        chk2("clr_ovf", {7'd0, ds_ovf}, {7'd0, dw_ovf}, 8'd0);
        chk2("clr_cp", {7'd0, ds_cp}, {7'd0, dw_cp}, 8'd0);
        chk2("clr_state", {6'd0, ds_state}, {6'd0, dw_state}, 8'd1);
        chk2("clr_upd0", {7'd0, ds_upd}, {7'd0, dw_upd}, 8'd0);
        clear_i = 1'b0;
        step();
        chk2("clr_upd1", {7'd0, ds_upd}, {7'd0, dw_upd}, 8'd1);
        chk2("clr_cp_late", {7'd0, ds_cp}, {7'd0, dw_cp}, 8'd0);
        step();
        chk2("clr_upd2", {7'd0, ds_upd}, {7'd0, dw_upd}, 8'd0);
        sensor_clean = 1'b0;
        repeat (10) step();

        // Clear held high: one refresh only
        clear_i = 1'b1;
        step();
        chk2("hold_clr_u0", {7'd0, ds_upd}, {7'd0, dw_upd}, 8'd0);
        step();
        chk2("hold_clr_u1", {7'd0, ds_upd}, {7'd0, dw_upd}, 8'd1);
        step();
        chk2("hold_clr_u2", {7'd0, ds_upd}, {7'd0, dw_upd}, 8'd0);
        step();
        chk2("hold_clr_u3", {7'd0, ds_upd}, {7'd0, dw_upd}, 8'd0);
        chk2("hold_clr_units", {4'd0, ds_units}, {4'd0, dw_units}, 8'd0);
        clear_i = 1'b0;
        step();

        // Reset while an object is present
        sensor_clean = 1'b1;
        step();
        chk2("mid_units", {4'd0, ds_units}, {4'd0, dw_units}, 8'd1);
        reset = 1'b1;
        step();
        chk2("mid_rst_state", {6'd0, ds_state}, {6'd0, dw_state}, 8'd0);
        chk2("mid_rst_units", {4'd0, ds_units}, {4'd0, dw_units}, 8'd0);
        chk2("mid_rst_cp", {7'd0, ds_cp}, {7'd0, dw_cp}, 8'd0);
        reset = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
